// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
// Module : oled_pkg
// Brief  : Shared encodings, command bytes and timing defaults for the OLED
//          power-up / frame-refresh sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package oled_pkg;

    localparam int unsigned T_VDD_DEF  = 100000;
    localparam int unsigned T_RES_DEF  = 300;
    localparam int unsigned T_VBAT_DEF = 10000000;

    localparam int CNT_W     = 24;
    localparam int FB_ADDR_W = 9;
    localparam int IDX_W     = 5;

    typedef logic [3:0] state_t;
    typedef logic [1:0] tx_state_t;

    localparam state_t PWR_VDD   = 4'd0;
    localparam state_t WAIT_VDD  = 4'd1;
    localparam state_t CMD_OFF   = 4'd2;
    localparam state_t RES_LOW   = 4'd3;
    localparam state_t RES_HIGH  = 4'd4;
    localparam state_t CMD_PUMP  = 4'd5;
    localparam state_t VBAT_ON   = 4'd6;
    localparam state_t WAIT_VBAT = 4'd7;
    localparam state_t CMD_CFG   = 4'd8;
    localparam state_t READY     = 4'd9;
    localparam state_t CMD_ADDR  = 4'd10;
    localparam state_t DATA      = 4'd11;
    localparam state_t FRAME_END = 4'd12;

    localparam tx_state_t TX_IDLE     = 2'd0;
    localparam tx_state_t TX_WAIT_LOW = 2'd1;
    localparam tx_state_t TX_HOLD     = 2'd2;
    localparam tx_state_t TX_WAIT_CLR = 2'd3;

    localparam logic [7:0] CMD_DISP_OFF  = 8'hAE;
    localparam logic [7:0] CMD_PUMP_SET  = 8'h8D;
    localparam logic [7:0] CMD_PUMP_ON   = 8'h14;
    localparam logic [7:0] CMD_PRECHG    = 8'hD9;
    localparam logic [7:0] CMD_PRECHG_V  = 8'hF1;
    localparam logic [7:0] CMD_SEG_REMAP = 8'hA1;
    localparam logic [7:0] CMD_COM_DIR   = 8'hC8;
    localparam logic [7:0] CMD_COM_PINS  = 8'hDA;
    localparam logic [7:0] CMD_ADDR_MODE = 8'h20;
    localparam logic [7:0] CMD_DISP_ON   = 8'hAF;
    localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
    localparam logic [7:0] CMD_COL_END   = 8'h7F;
    localparam logic [7:0] CMD_PAGE_END  = 8'h03;
    localparam logic [7:0] CMD_ZERO      = 8'h00;

    // One flat table: 0 off, 1-4 pump, 5-9 config, 10-17 address window
    localparam logic [IDX_W-1:0] IDX_OFF_LAST   = 5'd0;
    localparam logic [IDX_W-1:0] IDX_PUMP_LAST  = 5'd4;
    localparam logic [IDX_W-1:0] IDX_CFG_LAST   = 5'd9;
    localparam logic [IDX_W-1:0] IDX_ADDR_FIRST = 5'd10;
    localparam logic [IDX_W-1:0] IDX_ADDR_LAST  = 5'd17;

    function automatic logic [7:0] cmd_byte(input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:    b = CMD_DISP_OFF;
            5'd1:    b = CMD_PUMP_SET;
            5'd2:    b = CMD_PUMP_ON;
            5'd3:    b = CMD_PRECHG;
            5'd4:    b = CMD_PRECHG_V;
            5'd5:    b = CMD_SEG_REMAP;
            5'd6:    b = CMD_COM_DIR;
            5'd7:    b = CMD_COM_PINS;
            5'd8:    b = CMD_ADDR_MODE;
            5'd9:    b = CMD_DISP_ON;
            5'd10:   b = CMD_ADDR_MODE;
            5'd12:   b = CMD_COL_ADDR;
            5'd14:   b = CMD_COL_END;
            5'd15:   b = CMD_PAGE_ADDR;
            5'd17:   b = CMD_PAGE_END;
            default: b = CMD_ZERO;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/oled_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : oled_sequencer_if
// Brief  : Framebuffer, SPI byte and panel-pin signals of the OLED sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface oled_sequencer_if;
    import oled_pkg::*;

    logic                 start_frame;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [7:0]           fb_data;
    logic                 load_data;
    logic [7:0]           din;
    logic                 msg_done;
    logic                 oled_dc;
    logic                 oled_res;
    logic                 oled_vdd;
    logic                 oled_vbat;
    logic                 ready;
    logic                 busy;
    logic                 frame_done;

    modport master (
        input  start_frame, fb_data, msg_done,
        output fb_addr, load_data, din, oled_dc, oled_res, oled_vdd,
               oled_vbat, ready, busy, frame_done
    );

    modport slave (
        output start_frame, fb_data, msg_done,
        input  fb_addr, load_data, din, oled_dc, oled_res, oled_vdd,
               oled_vbat, ready, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/oled_byte_tx.sv
`default_nettype none
// ============================================================================
// Module : oled_byte_tx
// Brief  : Four-phase byte handshake towards the SPI controller.
// Rev    : 1.0  initial release
// ============================================================================
module oled_byte_tx
    import oled_pkg::*;
(
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic       start,
    input  wire logic [7:0] tx_byte,
    input  wire logic       tx_dc,
    output      logic       done,
    output      logic       load_data,
    output      logic [7:0] din,
    output      logic       oled_dc,
    input  wire logic       msg_done
);

    tx_state_t  r_state;
    logic [1:0] r_sync;
    logic       r_load;
    logic [7:0] r_din;
    logic       r_dc;
    logic       r_done;
    logic       w_synced;

    assign w_synced = r_sync[1];

    // din/dc are latched on start; they stay put until the next start, so they
    // are stable for the whole time load_data is high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= TX_IDLE;
            r_sync  <= 2'b00;
            r_load  <= 1'b0;
            r_din   <= 8'h00;
            r_dc    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], msg_done};
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (start) begin
                        r_din   <= tx_byte;
                        r_dc    <= tx_dc;
                        r_state <= TX_WAIT_LOW;
                    end
                end
                TX_WAIT_LOW: begin
                    if (!w_synced) begin
                        r_load  <= 1'b1;
                        r_state <= TX_HOLD;
                    end
                end
                TX_HOLD: begin
                    if (w_synced) begin
                        r_load  <= 1'b0;
                        r_state <= TX_WAIT_CLR;
                    end
                end
                TX_WAIT_CLR: begin
                    if (!w_synced) begin
                        r_done  <= 1'b1;
                        r_state <= TX_IDLE;
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign done      = r_done;
    assign load_data = r_load;
    assign din       = r_din;
    assign oled_dc   = r_dc;

endmodule
`default_nettype wire

// File: rtl/oled_sequencer.sv
`default_nettype none
// ============================================================================
// Module : oled_sequencer
// Brief  : SSD1306-style power-up sequence and 128x32 framebuffer refresh.
// Rev    : 1.0  initial release
// ============================================================================
module oled_sequencer
    import oled_pkg::*;
#(
    parameter int unsigned T_VDD  = T_VDD_DEF,
    parameter int unsigned T_RES  = T_RES_DEF,
    parameter int unsigned T_VBAT = T_VBAT_DEF
) (
    input wire logic          clock,
    input wire logic          reset,
    oled_sequencer_if.master  bus
);

    localparam logic [CNT_W-1:0] C_VDD_LAST  = CNT_W'(T_VDD - 1);
    localparam logic [CNT_W-1:0] C_RES_LAST  = CNT_W'(T_RES - 1);
    localparam logic [CNT_W-1:0] C_VBAT_LAST = CNT_W'(T_VBAT - 1);
    localparam logic [FB_ADDR_W-1:0] C_ADDR_LAST = '1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [1:0]           r_phase;
    logic [FB_ADDR_W-1:0] r_fb_addr;
    logic                 r_vdd;
    logic                 r_res;
    logic                 r_vbat;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_frame_done;

    logic                 w_is_wait;
    logic                 w_cnt_last;
    logic                 w_is_cmd;
    logic                 w_grp_last;
    logic                 w_cmd_next;
    logic                 w_cmd_end;
    logic                 w_data_next;
    logic                 w_data_end;
    logic                 w_tx_start;
    logic [7:0]           w_tx_byte;
    logic                 w_tx_dc;
    logic                 w_tx_done;

    always_comb begin
        w_is_wait  = 1'b0;
        w_cnt_last = 1'b0;
        w_is_cmd   = 1'b0;
        w_grp_last = 1'b0;
        case (r_state)
            WAIT_VDD:          begin w_is_wait = 1'b1; w_cnt_last = (r_cnt == C_VDD_LAST);  end
            RES_LOW, RES_HIGH: begin w_is_wait = 1'b1; w_cnt_last = (r_cnt == C_RES_LAST);  end
            WAIT_VBAT:         begin w_is_wait = 1'b1; w_cnt_last = (r_cnt == C_VBAT_LAST); end
            CMD_OFF:           begin w_is_cmd  = 1'b1; w_grp_last = (r_idx == IDX_OFF_LAST);  end
            CMD_PUMP:          begin w_is_cmd  = 1'b1; w_grp_last = (r_idx == IDX_PUMP_LAST); end
            CMD_CFG:           begin w_is_cmd  = 1'b1; w_grp_last = (r_idx == IDX_CFG_LAST);  end
            CMD_ADDR:          begin w_is_cmd  = 1'b1; w_grp_last = (r_idx == IDX_ADDR_LAST); end
            default:           ;
        endcase
    end

    // Data bytes use phases 0,1 to let fb_data settle for the held address,
    // phase 2 to launch the byte and phase 3 to wait for completion.
    assign w_cmd_next  = w_is_cmd && (r_phase == 2'd1) && w_tx_done;
    assign w_cmd_end   = w_cmd_next && w_grp_last;
    assign w_data_next = (r_state == DATA) && (r_phase == 2'd3) && w_tx_done;
    assign w_data_end  = w_data_next && (r_fb_addr == C_ADDR_LAST);

    assign w_tx_start = (w_is_cmd && (r_phase == 2'd0)) ||
                        ((r_state == DATA) && (r_phase == 2'd2));
    assign w_tx_dc    = (r_state == DATA);
    assign w_tx_byte  = w_tx_dc ? bus.fb_data : cmd_byte(r_idx);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PWR_VDD:   w_state_nxt = WAIT_VDD;
            WAIT_VDD:  if (w_cnt_last) w_state_nxt = CMD_OFF;
            CMD_OFF:   if (w_cmd_end)  w_state_nxt = RES_LOW;
            RES_LOW:   if (w_cnt_last) w_state_nxt = RES_HIGH;
            RES_HIGH:  if (w_cnt_last) w_state_nxt = CMD_PUMP;
            CMD_PUMP:  if (w_cmd_end)  w_state_nxt = VBAT_ON;
            VBAT_ON:   w_state_nxt = WAIT_VBAT;
            WAIT_VBAT: if (w_cnt_last) w_state_nxt = CMD_CFG;
            CMD_CFG:   if (w_cmd_end)  w_state_nxt = READY;
            READY:     if (bus.start_frame) w_state_nxt = CMD_ADDR;
            CMD_ADDR:  if (w_cmd_end)  w_state_nxt = DATA;
            DATA:      if (w_data_end) w_state_nxt = FRAME_END;
            FRAME_END: w_state_nxt = READY;
            default:   w_state_nxt = PWR_VDD;
        endcase
    end

    // Status flags are registered from the next state so that busy rises on
    // the very first edge after reset and on the edge that accepts a frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= PWR_VDD;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_phase      <= 2'd0;
            r_fb_addr    <= '0;
            r_vdd        <= 1'b1;
            r_res        <= 1'b1;
            r_vbat       <= 1'b1;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ready      <= (w_state_nxt == READY);
            r_busy       <= (w_state_nxt != READY);
            r_frame_done <= (w_state_nxt == FRAME_END);
            r_cnt        <= (w_is_wait && !w_cnt_last) ? r_cnt + 1'b1 : '0;

            if (r_state == PWR_VDD)                 r_vdd  <= 1'b0;
            if (r_state == VBAT_ON)                 r_vbat <= 1'b0;
            if ((r_state == CMD_OFF) && w_cmd_end)  r_res  <= 1'b0;
            if ((r_state == RES_LOW) && w_cnt_last) r_res  <= 1'b1;

            if (w_cmd_next)
                r_idx <= r_idx + 1'b1;
            else if ((r_state == READY) && bus.start_frame)
                r_idx <= IDX_ADDR_FIRST;

            if (w_is_cmd) begin
                if (r_phase == 2'd0)  r_phase <= 2'd1;
                else if (w_tx_done)   r_phase <= 2'd0;
            end else if (r_state == DATA) begin
                if (r_phase != 2'd3)  r_phase <= r_phase + 2'd1;
                else if (w_tx_done)   r_phase <= 2'd0;
            end else begin
                r_phase <= 2'd0;
            end

            // Nine-bit address wraps 511 -> 0 on its own after the last byte
            if (w_data_next)
                r_fb_addr <= r_fb_addr + 1'b1;
        end
    end

    oled_byte_tx u_byte_tx (
        .clock     (clock),
        .reset     (reset),
        .start     (w_tx_start),
        .tx_byte   (w_tx_byte),
        .tx_dc     (w_tx_dc),
        .done      (w_tx_done),
        .load_data (bus.load_data),
        .din       (bus.din),
        .oled_dc   (bus.oled_dc),
        .msg_done  (bus.msg_done)
    );

    assign bus.fb_addr    = r_fb_addr;
    assign bus.oled_res   = r_res;
    assign bus.oled_vdd   = r_vdd;
    assign bus.oled_vbat  = r_vbat;
    assign bus.ready      = r_ready;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_oled_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_oled_sequencer
// Brief  : Directed self-checking bench for oled_sequencer with an SPI model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_oled_sequencer;

    localparam int T_VDD  = 4;
    localparam int T_RES  = 3;
    localparam int T_VBAT = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    oled_sequencer_if bus();

    oled_sequencer #(.T_VDD(T_VDD), .T_RES(T_RES), .T_VBAT(T_VBAT)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] init_exp [10] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1,
                                  8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
    logic [7:0] addr_exp [8]  = '{8'h20, 8'h00, 8'h21, 8'h00,
                                  8'h7F, 8'h22, 8'h00, 8'h03};

    // SPI slave: msg_done rises 20 cycles after load_data, falls 2 after it drops
    logic spi_done  = 1'b0;
    logic hold_done = 1'b0;
    int   hi_cnt    = 0;
    int   lo_cnt    = 0;
    assign bus.msg_done = spi_done | hold_done;

    always @(negedge clk) begin
        if (bus.load_data && !spi_done) begin
            if (hi_cnt == 19) begin spi_done <= 1'b1; hi_cnt <= 0; end
            else hi_cnt <= hi_cnt + 1;
        end else hi_cnt <= 0;
        if (!bus.load_data && spi_done) begin
            if (lo_cnt == 1) begin spi_done <= 1'b0; lo_cnt <= 0; end
            else lo_cnt <= lo_cnt + 1;
        end else lo_cnt <= 0;
    end

    always @(posedge clk) bus.fb_data <= bus.fb_addr[7:0];

    logic [8:0] log_q [$];
    int         cyc_q [$];
    int         cyc = 0, vdd_fall_cyc = 0, vbat_fall_cyc = 0;
    int         res_low_cnt = 0, fd_cycles = 0, fd_pulses = 0;
    logic       prev_load = 1'b0, prev_vdd = 1'b1, prev_vbat = 1'b1, prev_fd = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.load_data && !prev_load) begin
            log_q.push_back({bus.oled_dc, bus.din});
            cyc_q.push_back(cyc);
        end
        if (!bus.oled_vdd && prev_vdd)   vdd_fall_cyc  <= cyc;
        if (!bus.oled_vbat && prev_vbat) vbat_fall_cyc <= cyc;
        if (!bus.oled_res)               res_low_cnt   <= res_low_cnt + 1;
        if (bus.frame_done)              fd_cycles     <= fd_cycles + 1;
        if (bus.frame_done && !prev_fd)  fd_pulses     <= fd_pulses + 1;
        prev_load <= bus.load_data;
        prev_vdd  <= bus.oled_vdd;
        prev_vbat <= bus.oled_vbat;
        prev_fd   <= bus.frame_done;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.ready === 1'b1) begin ok = 1'b1; return; end
            tick();
        end
    endtask

    task automatic pulse_start();
        bus.start_frame = 1'b1;
        tick();
        bus.start_frame = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] ctl;
        rst_n = 1'b0;
        bus.start_frame = 1'b0;
        hold_done = 1'b0;
        repeat (3) tick();
        ctl = {bus.load_data, bus.oled_dc, bus.oled_res, bus.oled_vdd,
               bus.oled_vbat, bus.ready, bus.busy};
        checks++;
        if (ctl !== 7'b0011100) begin
            errors++; $display("FAIL reset_ctl: got %b expected 0011100", ctl);
        end
        checks++;
        if (bus.din !== 8'h00 || bus.frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_din_fd: got din=%h fd=%b expected 00/0", bus.din, bus.frame_done);
        end
        checks++;
        if (bus.fb_addr !== 9'd0) begin
            errors++; $display("FAIL reset_fb_addr: got %0d expected 0", bus.fb_addr);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
            errors++; $display("FAIL reset_release_busy: got busy=%b ready=%b expected 1/0", bus.busy, bus.ready);
        end
    endtask

    task automatic test_init();
        int base = log_q.size();
        int res0 = res_low_cnt;
        int bad = 0;
        bit ok;
        wait_ready(3000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL init_ready_timeout: got ready=%b expected 1", bus.ready); end
        checks++;
        if (log_q.size() - base != 10) begin
            errors++; $display("FAIL init_byte_count: got %0d expected 10", log_q.size() - base);
        end
        for (int i = 0; i < 10; i++)
            if (log_q[base+i] !== {1'b0, init_exp[i]}) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL init_bytes: got %0d wrong {dc,byte} values (first %h) expected AE..AF dc=0", bad, log_q[base]);
        end
        checks++;
        if (cyc_q[base] - vdd_fall_cyc < T_VDD) begin
            errors++; $display("FAIL init_vdd_settle: got %0d cycles expected >= %0d", cyc_q[base] - vdd_fall_cyc, T_VDD);
        end
        checks++;
        if (res_low_cnt - res0 != T_RES) begin
            errors++; $display("FAIL init_res_pulse: got %0d cycles expected %0d", res_low_cnt - res0, T_RES);
        end
        checks++;
        if (cyc_q[base+5] - vbat_fall_cyc < T_VBAT) begin
            errors++; $display("FAIL init_vbat_settle: got %0d cycles expected >= %0d", cyc_q[base+5] - vbat_fall_cyc, T_VBAT);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.oled_vdd !== 1'b0 || bus.oled_vbat !== 1'b0 || bus.oled_res !== 1'b1) begin
            errors++; $display("FAIL init_ready_state: got busy=%b vdd=%b vbat=%b res=%b expected 0/0/0/1",
                               bus.busy, bus.oled_vdd, bus.oled_vbat, bus.oled_res);
        end
    endtask

    task automatic test_frame(input bit poke, input string tag);
        int base = log_q.size();
        int fd0 = fd_pulses;
        int fdc0 = fd_cycles;
        int bad_a = 0, bad_d = 0, first_d = -1;
        bit ok;
        pulse_start();
        checks++;
        if (bus.busy !== 1'b1 || bus.ready !== 1'b0) begin
            errors++; $display("FAIL %s_busy_after_start: got busy=%b ready=%b expected 1/0", tag, bus.busy, bus.ready);
        end
        if (poke) begin
            for (int i = 0; i < 3000 && log_q.size() - base < 40; i++) tick();
            pulse_start();
        end
        for (int i = 0; i < 25000 && fd_pulses == fd0; i++) tick();
        wait_ready(50, ok);
        repeat (60) tick();
        checks++;
        if (!ok || fd_pulses - fd0 != 1) begin
            errors++; $display("FAIL %s_frame_done_count: got %0d pulses ready=%b expected 1 pulse, ready", tag, fd_pulses - fd0, ok);
        end
        checks++;
        if (fd_cycles - fdc0 != 1) begin
            errors++; $display("FAIL %s_frame_done_width: got %0d cycles expected 1", tag, fd_cycles - fdc0);
        end
        checks++;
        if (log_q.size() - base != 520) begin
            errors++; $display("FAIL %s_byte_count: got %0d expected 520", tag, log_q.size() - base);
        end
        for (int i = 0; i < 8; i++)
            if (log_q[base+i] !== {1'b0, addr_exp[i]}) bad_a++;
        checks++;
        if (bad_a != 0) begin
            errors++; $display("FAIL %s_addr_bytes: got %0d wrong (first %h) expected 20 00 21 00 7F 22 00 03 dc=0", tag, bad_a, log_q[base]);
        end
        for (int i = 0; i < 512; i++)
            if (log_q[base+8+i] !== {1'b1, 8'(i)}) begin
                bad_d++;
                if (first_d < 0) first_d = i;
            end
        checks++;
        if (bad_d != 0) begin
            errors++; $display("FAIL %s_data_bytes: got %0d wrong, first at %0d = %h expected {1,%h}",
                               tag, bad_d, first_d, log_q[base+8+first_d], 8'(first_d));
        end
        checks++;
        if (bus.fb_addr !== 9'd0 || bus.ready !== 1'b1) begin
            errors++; $display("FAIL %s_end_state: got fb_addr=%0d ready=%b expected 0/1", tag, bus.fb_addr, bus.ready);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base = log_q.size();
        int fd0 = fd_pulses;
        int base2;
        int bad = 0;
        bit ok;
        pulse_start();
        for (int i = 0; i < 6000 && log_q.size() - base < 8 + 101; i++) tick();
        checks++;
        if (log_q.size() - base < 8 + 101) begin
            errors++; $display("FAIL abort_reach_byte100: got %0d bytes expected 109", log_q.size() - base);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.load_data, bus.oled_vdd, bus.oled_vbat, bus.oled_res, bus.busy, bus.fb_addr} !== {5'b01110, 9'd0}) begin
            errors++; $display("FAIL abort_immediate: got load=%b vdd=%b vbat=%b res=%b busy=%b addr=%0d expected 0/1/1/1/0/0",
                               bus.load_data, bus.oled_vdd, bus.oled_vbat, bus.oled_res, bus.busy, bus.fb_addr);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        base2 = log_q.size();
        repeat (20) tick();
        pulse_start();
        wait_ready(3000, ok);
        repeat (40) tick();
        for (int i = 0; i < 10; i++)
            if (log_q[base2+i] !== {1'b0, init_exp[i]}) bad++;
        checks++;
        if (!ok || log_q.size() - base2 != 10 || bad != 0) begin
            errors++; $display("FAIL abort_restart: got ready=%b bytes=%0d wrong=%0d first=%h expected 1/10/0/0AE",
                               ok, log_q.size() - base2, bad, log_q[base2]);
        end
        checks++;
        if (fd_pulses != fd0) begin
            errors++; $display("FAIL abort_frame_count: got %0d expected %0d", fd_pulses, fd0);
        end
    endtask

    task automatic test_msg_done_hold();
        int base;
        int viol = 0;
        hold_done = 1'b1;
        repeat (4) tick();
        base = log_q.size();
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            if (bus.load_data !== 1'b0) viol++;
            tick();
        end
        checks++;
        if (viol != 0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL hold_no_load: got %0d load cycles busy=%b expected 0/1", viol, bus.busy);
        end
        hold_done = 1'b0;
        for (int i = 0; i < 200 && log_q.size() == base; i++) tick();
        checks++;
        if (log_q.size() == base || log_q[base] !== 9'h020) begin
            errors++; $display("FAIL hold_first_byte: got %0d bytes first=%h expected 020", log_q.size() - base, log_q[base]);
        end
        rst_n = 1'b0;
        tick();
    endtask

    initial begin
        bus.start_frame = 1'b0;
        test_reset();
        test_init();
        test_frame(1'b0, "frame");
        test_frame(1'b1, "ignore_start");
        test_reset_mid_frame();
        test_msg_done_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/oled_sequencer.md
OLED_SEQUENCER -- requirements
Module: oled_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): T_VDD, 100000, VDD-on settle cycles; T_RES, 300, oled_res low-pulse cycles; T_VBAT, 10000000, VBAT-on settle cycles.
REQ-002 clock  in  1  100 MHz system clock; all logic on posedge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start_frame  in  1  frame-refresh request, sampled only in READY.
REQ-005 fb_addr  out  9  framebuffer read address (128x32 px / 8 = 512 bytes).
REQ-006 fb_data  in  8  framebuffer byte, valid one cycle after fb_addr.
REQ-007 load_data  out  1  byte request to the downstream SPI controller.
REQ-008 din  out  8  byte to transmit, MSB first on the wire.
REQ-009 msg_done  in  1  SPI byte-complete flag, asynchronous to clock.
REQ-010 oled_dc  out  1  0 = command byte, 1 = display data byte.
REQ-011 oled_res  out  1  panel reset, active-low.
REQ-012 oled_vdd  out  1  logic supply enable, active-low.
REQ-013 oled_vbat  out  1  panel supply enable, active-low.
REQ-014 ready  out  1  initialisation complete, idle.
REQ-015 busy  out  1  initialisation or frame transfer in progress.
REQ-016 frame_done  out  1  one-cycle pulse after the last data byte completes.

Function
REQ-017 msg_done SHALL pass through a 2-flop synchroniser before use.
REQ-018 Byte handshake: wait synced msg_done=0; drive din/oled_dc and set load_data=1; hold din/oled_dc stable until synced msg_done=1; then clear load_data; next byte only after synced msg_done=0.
REQ-019 Main FSM states SHALL be PWR_VDD, WAIT_VDD, CMD_OFF, RES_LOW, RES_HIGH, CMD_PUMP, VBAT_ON, WAIT_VBAT, CMD_CFG, READY, CMD_ADDR, DATA, FRAME_END.
REQ-020 Init order after reset release: oled_vdd=0, wait T_VDD; send 0xAE; oled_res=0 for T_RES; oled_res=1, wait T_RES; send 0x8D,0x14,0xD9,0xF1; oled_vbat=0, wait T_VBAT; send 0xA1,0xC8,0xDA,0x20,0xAF; enter READY.
REQ-021 All init and address bytes SHALL be sent with oled_dc=0.
REQ-022 In READY, ready=1 and busy=0; otherwise ready=0 and busy=1.
REQ-023 In READY with start_frame=1: next cycle busy=1; send 0x20,0x00,0x21,0x00,0x7F,0x22,0x00,0x03 (dc=0); then 512 bytes fb_data[0..511] with dc=1.
REQ-024 fb_addr SHALL be presented at least one cycle before din is loaded from fb_data.
REQ-025 After byte 511 completes, frame_done SHALL pulse exactly one cycle, fb_addr SHALL wrap to 0, and the FSM SHALL return to READY.
REQ-026 start_frame SHALL be ignored outside READY; a request is never queued.
REQ-027 If synced msg_done=1 on entry to a send, load_data SHALL NOT assert until it returns to 0.
REQ-028 Delay counters SHALL be 24 bits wide and count from 0 to T-1 inclusive (T cycles exactly).

Reset
REQ-029 While reset=0, outputs SHALL hold: load_data=0, din=0x00, oled_dc=0, oled_res=1, oled_vdd=1, oled_vbat=1, ready=0, busy=0, frame_done=0, fb_addr=0.
REQ-030 Reset asserted mid-operation SHALL force REQ-029 values immediately; on release, the full sequence SHALL restart at PWR_VDD, with busy=1 from the first clock edge.

Structure
REQ-031 Package oled_pkg SHALL hold the FSM state encoding, the init/address command byte constants, and the default T_* values.
REQ-032 The REQ-018 handshake SHALL be one sub-module, oled_byte_tx (start/done to the FSM; load_data/din/oled_dc/msg_done to the SPI side).

Verification
REQ-033 Use T_VDD=4, T_RES=3, T_VBAT=10 with an SPI model that raises msg_done 20 cycles after load_data and clears it 2 cycles after load_data falls.
REQ-034 Release reset -> capture bytes AE,8D,14,D9,F1,A1,C8,DA,20,AF (dc=0); oled_vdd low at least 4 cycles before AE; oled_res low exactly 3 cycles; oled_vbat low at least 10 cycles before A1; then ready=1.
REQ-035 Pulse start_frame with fb[i]=i[7:0] -> 8 address bytes (dc=0), then 512 bytes 00..FF,00..FF (dc=1); one frame_done pulse; fb_addr returns to 0.
REQ-036 Pulse start_frame during init and during a frame -> no extra bytes sent; frame count unchanged.
REQ-037 Assert reset at data byte 100 -> load_data=0 and power pins high immediately; after release, sequence restarts with AE.
REQ-038 Hold msg_done=1 at READY, then pulse start_frame -> load_data stays 0 until msg_done falls; first byte is 0x20.
